// File: rtl/spi_mem_responder.sv
// ---------------------------------------------------------------------------
// spi_mem_responder
//
// SPI mode-0 slave that acts as the word-addressed external memory for the
// Hack CPU master port. The SPI pins are oversampled in the clk domain. The
// block decodes READ (0x03) and WRITE (0x02) frames and serves 16-bit words
// from an internal RAM. The address auto-increments and wraps at the top of
// the RAM.
//
// Frame: 8-bit opcode, 16-bit address (only the low ADDR_W bits are used),
// then a stream of 16-bit data words. All fields are sent MSB first.
//
// Optional build macro: SPI_MEM_READ_ID_EN
//   When defined, opcode 0x9F skips the address phase and streams DEV_ID
//   repeatedly. When undefined, 0x9F is treated like any other unknown
//   opcode and the frame is ignored.
//
// Ports:
//   clk        system clock
//   resetb     asynchronous active-low reset
//   sclk_i     SPI clock from the master (idle low)
//   csb_i      SPI chip select, active low
//   mosi_i     master-out data
//   miso_o     slave-out data
//   miso_oe_o  high while read data is being driven
//   busy_o     high while a frame is in progress
//   bd_we_i    backdoor write strobe (bench / loader preload)
//   bd_addr_i  backdoor word address
//   bd_data_i  backdoor write data
// ---------------------------------------------------------------------------
module spi_mem_responder #(
  parameter int          ADDR_W = 10,
  parameter logic [15:0] DEV_ID = 16'h4A43
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              sclk_i,
  input  logic              csb_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic              busy_o,
  input  logic              bd_we_i,
  input  logic [ADDR_W-1:0] bd_addr_i,
  input  logic [15:0]       bd_data_i
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ,
    WRITE,
    IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        sclk_sync, csb_sync, mosi_sync;
  logic              sclk_prev, csb_prev;
  logic              sclk_s, csb_s, mosi_s;
  logic              sclk_rise, sclk_fall, csb_fall;

  logic [15:0]       shift_q;
  logic [15:0]       shift_in;
  logic [15:0]       tx_q;
  logic [3:0]        bit_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_mode_q;
  logic              id_mode_q;
  logic              load_pend_q;

  logic              cmd_done;
  logic              id_start;
  logic              addr_done;
  logic              word_wr;
  logic              word_next;

  logic [15:0]       mem [0:DEPTH-1];
  logic [15:0]       ram_q;

  // The three SPI pins are asynchronous to clk, so each one passes through a
  // two-flop synchronizer. One more flop holds the previous synced sclk/csb
  // level for edge detection. The csb chain resets low. As a result, a csb
  // that is already low when reset is released does not look like a new
  // falling edge, and the responder waits for the master to start a fresh
  // frame.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sclk_sync <= 2'b00;
      csb_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_prev <= 1'b0;
      csb_prev  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk_i};
      csb_sync  <= {csb_sync[0], csb_i};
      mosi_sync <= {mosi_sync[0], mosi_i};
      sclk_prev <= sclk_sync[1];
      csb_prev  <= csb_sync[1];
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign csb_s     = csb_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign csb_fall  = csb_prev & ~csb_s;

  assign shift_in = {shift_q[14:0], mosi_s};
  assign addr_inc = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign busy_o   = ~csb_s & (state_q != IDLE);

  // The state register only tracks the protocol phase. All per-bit work
  // happens in the datapath block below.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and single-cycle strobes. A high synced csb aborts
  // the frame from any state. The strobes mark the bit that completes each
  // field, so the datapath and the RAM can act on that same cycle.
  always_comb begin
    state_d   = state_q;
    cmd_done  = 1'b0;
    id_start  = 1'b0;
    addr_done = 1'b0;
    word_wr   = 1'b0;
    word_next = 1'b0;
    if (csb_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (csb_fall) state_d = CMD;
        end
        CMD: begin
          if (sclk_rise && bit_cnt == 4'd7) begin
            cmd_done = 1'b1;
            case (shift_in[7:0])
              8'h03:   state_d = ADDR;
              8'h02:   state_d = ADDR;
`ifdef SPI_MEM_READ_ID_EN
              8'h9F: begin
                state_d  = READ;
                id_start = 1'b1;
              end
`endif
              default: state_d = IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (sclk_rise && bit_cnt == 4'd15) begin
            addr_done = 1'b1;
            state_d   = rd_mode_q ? READ : WRITE;
          end
        end
        READ: begin
          if (sclk_fall && bit_cnt == 4'd15) word_next = 1'b1;
        end
        WRITE: begin
          if (sclk_rise && bit_cnt == 4'd15) word_wr = 1'b1;
        end
        IGNORE: begin
          state_d = IGNORE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The RAM read address runs one step ahead of the pointer. It uses the
  // new address while the last address bit arrives, and the incremented
  // address on the final bit of each read word. This way the next word sits
  // in ram_q one cycle later, which is well before the next sclk falling
  // edge.
  always_comb begin
    rd_addr = addr_q;
    if (addr_done) begin
      rd_addr = shift_in[ADDR_W-1:0];
    end else if (word_next) begin
      rd_addr = addr_inc;
    end
  end

  // Datapath: bit counter, receive shifter, transmit shifter, address
  // pointer and the registered MISO outputs. Received bits are taken on
  // synced sclk rising edges. Read bits go out on falling edges, so the
  // master sees them stable at its next rising edge.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      shift_q     <= 16'h0000;
      tx_q        <= 16'h0000;
      bit_cnt     <= 4'd0;
      addr_q      <= '0;
      rd_mode_q   <= 1'b0;
      id_mode_q   <= 1'b0;
      load_pend_q <= 1'b0;
      miso_o      <= 1'b0;
      miso_oe_o   <= 1'b0;
    end else begin
      load_pend_q <= 1'b0;
      if (csb_s) begin
        shift_q   <= 16'h0000;
        bit_cnt   <= 4'd0;
        id_mode_q <= 1'b0;
        miso_o    <= 1'b0;
        miso_oe_o <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            bit_cnt <= 4'd0;
          end
          CMD: begin
            if (sclk_rise) begin
              shift_q <= shift_in;
              bit_cnt <= cmd_done ? 4'd0 : bit_cnt + 4'd1;
            end
            if (cmd_done) begin
              rd_mode_q   <= (shift_in[7:0] == 8'h03);
              id_mode_q   <= id_start;
              load_pend_q <= id_start;
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              shift_q <= shift_in;
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (addr_done) begin
              addr_q      <= shift_in[ADDR_W-1:0];
              load_pend_q <= rd_mode_q;
            end
          end
          READ: begin
            if (load_pend_q) begin
              tx_q <= id_mode_q ? DEV_ID : ram_q;
            end
            if (sclk_fall) begin
              miso_o    <= tx_q[15];
              miso_oe_o <= 1'b1;
              tx_q      <= {tx_q[14:0], 1'b0};
              bit_cnt   <= bit_cnt + 4'd1;
            end
            if (word_next) begin
              addr_q      <= addr_inc;
              load_pend_q <= 1'b1;
            end
          end
          WRITE: begin
            if (sclk_rise) begin
              shift_q <= shift_in;
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (word_wr) begin
              addr_q <= addr_inc;
            end
          end
          IGNORE: begin
            miso_o    <= 1'b0;
            miso_oe_o <= 1'b0;
          end
          default: begin
            bit_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

  // Single write port shared by the SPI and the backdoor. An SPI write on
  // the same cycle takes priority, so a loader running in the background
  // can never overwrite a word the CPU has just stored.
  always_ff @(posedge clk) begin
    if (word_wr) begin
      mem[addr_q] <= shift_in;
    end else if (bd_we_i) begin
      mem[bd_addr_i] <= bd_data_i;
    end
    ram_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_mem_responder
//
// Directed bench for spi_mem_responder with ADDR_W=10. A bit-banged SPI
// mode-0 master runs 10 clk per sclk period. MISO is sampled at the end of
// each low phase, which is where a mode-0 master would latch it.
// Build with +define+SPI_MEM_READ_ID_EN to exercise the READ_ID opcode.
// ---------------------------------------------------------------------------
module tb_spi_mem_responder;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              resetb;
  logic              sclk_i;
  logic              csb_i;
  logic              mosi_i;
  logic              miso_o;
  logic              miso_oe_o;
  logic              busy_o;
  logic              bd_we_i;
  logic [ADDR_W-1:0] bd_addr_i;
  logic [15:0]       bd_data_i;

  int checks;
  int failures;
  int oe_count;

  logic [31:0] got;
  logic [31:0] dummy;
  int          oe_before;

  spi_mem_responder #(.ADDR_W(ADDR_W), .DEV_ID(16'h4A43)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .sclk_i    (sclk_i),
    .csb_i     (csb_i),
    .mosi_i    (mosi_i),
    .miso_o    (miso_o),
    .miso_oe_o (miso_oe_o),
    .busy_o    (busy_o),
    .bd_we_i   (bd_we_i),
    .bd_addr_i (bd_addr_i),
    .bd_data_i (bd_data_i)
  );

  // 100 MHz system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts the cycles in which the responder drives MISO. This lets a test
  // assert that the output enable never rose during a frame.
  always @(posedge clk) begin
    if (miso_oe_o === 1'b1) oe_count <= oe_count + 1;
  end

  // Counts one comparison and reports it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advances n clock edges and settles 1 ns past the last one
  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shifts n bits of val out on MOSI, MSB first, and collects the MISO bits
  task automatic applyStimulus(input logic [31:0] val, input int n,
                               output logic [31:0] rx);
    rx = 32'h0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi_i = val[i];
      waitClk(5);
      rx = {rx[30:0], miso_o};
      sclk_i = 1'b1;
      waitClk(5);
      sclk_i = 1'b0;
    end
  endtask

  task automatic frameStart();
    csb_i = 1'b0;
    waitClk(4);
  endtask

  task automatic frameEnd();
    mosi_i = 1'b0;
    waitClk(4);
    csb_i = 1'b1;
    waitClk(6);
  endtask

  task automatic bdWrite(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    bd_addr_i = a;
    bd_data_i = d;
    bd_we_i   = 1'b1;
    waitClk(1);
    bd_we_i   = 1'b0;
  endtask

  task automatic spiRead(input logic [15:0] a, input int nbits,
                         output logic [31:0] rx);
    logic [31:0] tmp;
    frameStart();
    applyStimulus(32'h03, 8, tmp);
    applyStimulus({16'h0, a}, 16, tmp);
    applyStimulus(32'h0, nbits, rx);
    frameEnd();
  endtask

  task automatic spiWrite2(input logic [15:0] a, input logic [15:0] w0,
                           input logic [15:0] w1);
    logic [31:0] tmp;
    frameStart();
    applyStimulus(32'h02, 8, tmp);
    applyStimulus({16'h0, a}, 16, tmp);
    applyStimulus({w0, w1}, 32, tmp);
    frameEnd();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    oe_count  = 0;
    resetb    = 1'b0;
    sclk_i    = 1'b0;
    csb_i     = 1'b1;
    mosi_i    = 1'b0;
    bd_we_i   = 1'b0;
    bd_addr_i = '0;
    bd_data_i = 16'h0;
    waitClk(3);
    checkOutput("rst_miso", {31'h0, miso_o}, 32'h0);
    checkOutput("rst_oe", {31'h0, miso_oe_o}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy_o}, 32'h0);
    resetb = 1'b1;
    waitClk(4);

    // Backdoor preload, then a two-word sequential read
    bdWrite(10'd5, 16'hBEEF);
    bdWrite(10'd6, 16'h1234);
    frameStart();
    checkOutput("busy_in_frame", {31'h0, busy_o}, 32'h1);
    applyStimulus(32'h03, 8, dummy);
    applyStimulus(32'h0005, 16, dummy);
    checkOutput("oe_before_data", {31'h0, miso_oe_o}, 32'h0);
    applyStimulus(32'h0, 32, got);
    checkOutput("read_beef_1234", got, 32'hBEEF1234);
    checkOutput("oe_during_read", {31'h0, miso_oe_o}, 32'h1);
    frameEnd();
    checkOutput("oe_after_frame", {31'h0, miso_oe_o}, 32'h0);
    checkOutput("busy_after_frame", {31'h0, busy_o}, 32'h0);

    // Reset in the middle of a read data phase
    frameStart();
    applyStimulus(32'h03, 8, dummy);
    applyStimulus(32'h0005, 16, dummy);
    applyStimulus(32'h0, 8, dummy);
    resetb = 1'b0;
    #1;
    checkOutput("midrst_miso", {31'h0, miso_o}, 32'h0);
    checkOutput("midrst_oe", {31'h0, miso_oe_o}, 32'h0);
    checkOutput("midrst_busy", {31'h0, busy_o}, 32'h0);
    waitClk(2);
    resetb = 1'b1;
    oe_before = oe_count;
    applyStimulus(32'h03, 8, dummy);
    checkOutput("postrst_busy", {31'h0, busy_o}, 32'h0);
    checkOutput("postrst_no_oe", oe_count - oe_before, 32'h0);
    frameEnd();

    // Write two words, then read them back
    spiWrite2(16'h0010, 16'hA5A5, 16'h5A5A);
    spiRead(16'h0010, 32, got);
    checkOutput("wr_rd_0010", got, 32'hA5A55A5A);

    // Address wrap on write and read
    spiWrite2(16'h03FF, 16'h1111, 16'h2222);
    spiRead(16'h0000, 16, got);
    checkOutput("wrap_wr_at_0", got, 32'h00002222);
    spiRead(16'h03FF, 32, got);
    checkOutput("wrap_rd", got, 32'h11112222);

    // Aborted write after 9 data bits leaves the target untouched
    bdWrite(10'h020, 16'h7777);
    frameStart();
    applyStimulus(32'h02, 8, dummy);
    applyStimulus(32'h0020, 16, dummy);
    applyStimulus(32'h1FF, 9, dummy);
    frameEnd();
    spiRead(16'h0020, 16, got);
    checkOutput("abort_unchanged", got, 32'h00007777);

    // Unknown opcode never enables MISO
    oe_before = oe_count;
    frameStart();
    applyStimulus(32'h55, 8, dummy);
    applyStimulus(32'hFFFF_FFFF, 32, dummy);
    frameEnd();
    checkOutput("unknown_op_no_oe", oe_count - oe_before, 32'h0);

    // Backdoor write in the same cycle as the SPI write to that address.
    // The final sclk rise reaches the synced edge detector two edges later,
    // and the SPI write lands on the third edge. The backdoor strobe is
    // therefore held through exactly those three edges.
    frameStart();
    applyStimulus(32'h02, 8, dummy);
    applyStimulus(32'h0030, 16, dummy);
    applyStimulus(32'hC3C3 >> 1, 15, dummy);
    mosi_i = 1'b1;
    waitClk(5);
    bd_addr_i = 10'h030;
    bd_data_i = 16'hDEAD;
    bd_we_i   = 1'b1;
    sclk_i    = 1'b1;
    waitClk(3);
    bd_we_i   = 1'b0;
    waitClk(2);
    sclk_i    = 1'b0;
    frameEnd();
    spiRead(16'h0030, 16, got);
    checkOutput("collision_spi_wins", got, 32'h0000C3C3);

    // READ_ID opcode
    oe_before = oe_count;
    frameStart();
    applyStimulus(32'h9F, 8, dummy);
    applyStimulus(32'h0, 32, got);
    frameEnd();
`ifdef SPI_MEM_READ_ID_EN
    checkOutput("read_id", got, 32'h4A434A43);
`else
    checkOutput("read_id_disabled_no_oe", oe_count - oe_before, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
